// File: rtl/fwd_stage.sv
// Buffered forwarding stage for one mesh direction: legal packets queue in a small FIFO,
// and the head leaves via the forward port (hop adjusted) or the local port. Optional: FWD_ERR_CNT_EN.
module fwd_stage #(
    parameter int PKT_W     = 16,
    parameter int HOP_LSB   = 8,
    parameter int HOP_W     = 4,
    parameter int DIR_NEG   = 0,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] in_pkt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] fwd_pkt,
    output logic             fwd_valid,
    input  logic             fwd_ready,
    output logic [PKT_W-1:0] loc_pkt,
    output logic             loc_valid,
    input  logic             loc_ready,
    output logic             err_pulse
`ifdef FWD_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [HOP_W-1:0] HOP_ONE  = HOP_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOP_LSB + HOP_W > PKT_W || ERR_CNT_W < 1)
    begin : g_bad_params
        $error("fwd_stage: illegal parameter combination");
    end

    // True when the hop value still points along this stage's direction.
    function automatic logic hop_fwd(input logic [HOP_W-1:0] h);
        if (DIR_NEG != 0)
            return h[HOP_W-1];
        else
            return !h[HOP_W-1] && (h != '0);
    endfunction

    logic [PKT_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_pulse_reg;

    logic [HOP_W-1:0] in_hop;
    logic             in_legal;
    logic             accept;
    logic             push;
    logic             drop;
    logic             pop;
    logic             empty;
    logic [PKT_W-1:0] head;
    logic [HOP_W-1:0] head_hop;
    logic             head_local;

    assign in_hop   = in_pkt[HOP_LSB +: HOP_W];
    assign in_legal = (in_hop == '0) || hop_fwd(in_hop);
    assign in_ready = (count_reg != CNT_FULL);
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_legal;
    assign drop     = accept && !in_legal;
    assign empty    = (count_reg == '0);

    // Only legal packets are stored, so a non-zero head hop is always a forward head.
    assign head       = mem_reg[rd_ptr_reg];
    assign head_hop   = head[HOP_LSB +: HOP_W];
    assign head_local = (head_hop == '0);
    assign pop        = !empty && (head_local ? loc_ready : fwd_ready);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push)
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (pop)
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            err_pulse_reg <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= in_pkt;
    end

    // HOP_W-bit wraparound gives the same bits as widening, adjusting and truncating.
    always_comb begin
        fwd_pkt   = '0;
        loc_pkt   = '0;
        fwd_valid = 1'b0;
        loc_valid = 1'b0;
        if (!empty) begin
            if (head_local) begin
                loc_valid = 1'b1;
                loc_pkt   = head;
            end else begin
                fwd_valid = 1'b1;
                fwd_pkt   = head;
                fwd_pkt[HOP_LSB +: HOP_W] = (DIR_NEG != 0) ? (head_hop + HOP_ONE)
                                                           : (head_hop - HOP_ONE);
            end
        end
    end

    assign err_pulse = err_pulse_reg;

`ifdef FWD_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
    logic [ERR_CNT_W-1:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            err_count_reg <= '0;
        else if (drop && (err_count_reg != '1))
            err_count_reg <= err_count_reg + ERR_ONE;
    end

    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_fwd_stage.sv
// Scoreboard bench for fwd_stage: a DIR_NEG=0 instance checked through an expected-output
// queue and monitor, plus a DIR_NEG=1 instance checked with directed vectors.
module tb_fwd_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in_pkt, fwd_pkt, loc_pkt;
    logic        in_valid, in_ready, fwd_valid, fwd_ready, loc_valid, loc_ready, err_pulse;
    logic [15:0] n_in_pkt, n_fwd_pkt, n_loc_pkt;
    logic        n_in_valid, n_in_ready, n_fwd_valid, n_fwd_ready, n_loc_valid, n_loc_ready;
    logic        n_err_pulse;
`ifdef FWD_ERR_CNT_EN
    logic [1:0]  err_count;
    logic [7:0]  n_err_count;
`endif

    fwd_stage #(.DIR_NEG(0), .ERR_CNT_W(2)) u_pos (
        .clk(clk), .rst(rst),
        .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready),
        .fwd_pkt(fwd_pkt), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .loc_pkt(loc_pkt), .loc_valid(loc_valid), .loc_ready(loc_ready),
        .err_pulse(err_pulse)
`ifdef FWD_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    fwd_stage #(.DIR_NEG(1)) u_neg (
        .clk(clk), .rst(rst),
        .in_pkt(n_in_pkt), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .fwd_pkt(n_fwd_pkt), .fwd_valid(n_fwd_valid), .fwd_ready(n_fwd_ready),
        .loc_pkt(n_loc_pkt), .loc_valid(n_loc_valid), .loc_ready(n_loc_ready),
        .err_pulse(n_err_pulse)
`ifdef FWD_ERR_CNT_EN
        , .err_count(n_err_count)
`endif
    );

    typedef struct packed {
        logic        is_loc;
        logic [15:0] pkt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   pulse_cnt    = 0;
    int   ill_sent     = 0;
    bit   err_exp      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake pops one expected packet.
    always @(negedge clk) begin
        if (!rst) begin
            if (fwd_valid && loc_valid)
                check("exclusive_valid", 32'(loc_valid), 32'd0);
            if ((fwd_valid && fwd_ready) || (loc_valid && loc_ready)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {14'd0, fwd_valid, loc_valid, loc_valid ? loc_pkt : fwd_pkt}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_pkt", {15'd0, loc_valid, loc_valid ? loc_pkt : fwd_pkt}, {15'd0, e.is_loc, e.pkt});
                    $display("[TB] out %s %h (expected %h)", loc_valid ? "loc" : "fwd",
                             loc_valid ? loc_pkt : fwd_pkt, e.pkt);
                end
                check("idle_port_zero", 32'(loc_valid ? fwd_pkt : loc_pkt), 32'd0);
            end
            if (err_pulse || err_exp)
                check("err_pulse", 32'(err_pulse), 32'(err_exp));
            if (err_pulse)
                pulse_cnt++;
        end
        err_exp = 1'b0;
    end

    task automatic send(input logic [15:0] p, input bit legal, input bit is_loc, input logic [15:0] req);
        int n = 0;
        bit ok;
        in_pkt   = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        ok = in_ready;
        if (!ok)
            check("send_timeout", 32'(in_ready), 32'd1);
        else if (legal)
            exp_q.push_back('{is_loc, req});
        @(posedge clk);
        #1;
        if (ok && !legal) begin
            err_exp = 1'b1;
            ill_sent++;
        end
        in_valid = 1'b0;
        $display("[TB] in  %h %s", p, legal ? "legal" : "illegal");
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(name, exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic neg_case(input logic [15:0] p, input bit fv, input logic [15:0] fp,
                            input bit lv, input logic [15:0] lp, input bit ev);
        n_in_pkt   = p;
        n_in_valid = 1'b1;
        @(negedge clk);
        check("neg_in_ready", 32'(n_in_ready), 32'd1);
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        @(negedge clk);
        check("neg_fwd_valid", 32'(n_fwd_valid), 32'(fv));
        check("neg_fwd_pkt", 32'(n_fwd_pkt), 32'(fp));
        check("neg_loc_valid", 32'(n_loc_valid), 32'(lv));
        check("neg_loc_pkt", 32'(n_loc_pkt), 32'(lp));
        check("neg_err_pulse", 32'(n_err_pulse), 32'(ev));
        $display("[TB] neg in %h -> fwd %b:%h loc %b:%h err %b", p, n_fwd_valid, n_fwd_pkt,
                 n_loc_valid, n_loc_pkt, n_err_pulse);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        check({tag, "_loc_valid"}, 32'(loc_valid), 32'd0);
        check({tag, "_fwd_pkt"}, 32'(fwd_pkt), 32'd0);
        check({tag, "_loc_pkt"}, 32'(loc_pkt), 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
`ifdef FWD_ERR_CNT_EN
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit accepted, acc_now;
        int base;
        rst = 1'b1;
        in_pkt = '0;  in_valid = 1'b0;  fwd_ready = 1'b1;  loc_ready = 1'b1;
        n_in_pkt = '0; n_in_valid = 1'b0; n_fwd_ready = 1'b1; n_loc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_neg_in_ready", 32'(n_in_ready), 32'd1);
        check("reset_neg_valids", {30'd0, n_fwd_valid, n_loc_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Illegal then legal forward, plus hop-range boundaries.
        send(16'h0A35, 1'b0, 1'b0, 16'h0000);
        send(16'h0335, 1'b1, 1'b0, 16'h0235);
        send(16'h0800, 1'b0, 1'b0, 16'h0000);
        send(16'h0735, 1'b1, 1'b0, 16'h0635);
        send(16'h0135, 1'b1, 1'b0, 16'h0035);
        drain("drain_t1");

        // Local delivery and its one-cycle latency, then a mixed back-to-back stream.
        send(16'h00C1, 1'b1, 1'b1, 16'h00C1);
        @(negedge clk);
        check("loc_latency_valid", 32'(loc_valid), 32'd1);
        check("loc_latency_pkt", 32'(loc_pkt), 32'h00C1);
        check("loc_latency_fwd_valid", 32'(fwd_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'hF012, 1'b1, 1'b1, 16'hF012);
        send(16'hF234, 1'b1, 1'b0, 16'hF134);
        send(16'h0056, 1'b1, 1'b1, 16'h0056);
        drain("drain_t2");

        // Negative-direction instance.
        neg_case(16'h0F12, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0);
        neg_case(16'h0812, 1'b1, 16'h0912, 1'b0, 16'h0000, 1'b0);
        neg_case(16'h0112, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        neg_case(16'h0012, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b0);

        // Fill with the forward port stalled, then release.
        fwd_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'h2700 + 16'(i), 1'b1, 1'b0, 16'h2600 + 16'(i));
        in_pkt   = 16'h2704;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(fwd_valid), 32'd1);
            check("stall_hold", 32'(fwd_pkt), 32'h2600);
        end
        @(posedge clk);
        #1;
        fwd_ready = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc_now = 1'b0;
            @(negedge clk);
            check("drain_one_per_cycle", 32'(fwd_valid), 32'd1);
            if (!accepted && in_ready) begin
                exp_q.push_back('{1'b0, 16'h2604});
                acc_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                in_valid = 1'b0;
                accepted = 1'b1;
            end
        end
        check("fifth_accepted", 32'(accepted), 32'd1);
        drain("drain_t4");

        // Two entries resident, ten cycles of simultaneous push and pop.
        fwd_ready = 1'b0;
        send(16'h5100, 1'b1, 1'b0, 16'h5000);
        send(16'h5101, 1'b1, 1'b0, 16'h5001);
        fwd_ready = 1'b1;
        base = tests_failed;
        for (int i = 2; i < 12; i++)
            send(16'h5100 + 16'(i), 1'b1, 1'b0, 16'h5000 + 16'(i));
        fwd_ready = 1'b0;
        check("stream_clean", tests_failed - base, 32'd0);
        send(16'h5112, 1'b1, 1'b0, 16'h5012);
        send(16'h5113, 1'b1, 1'b0, 16'h5013);
        @(negedge clk);
        check("occupancy_two_then_full", 32'(in_ready), 32'd0);
        check("stream_head", 32'(fwd_pkt), 32'h500A);

        // Reset with packets held and an offered packet on the reset edge.
        @(posedge clk);
        #1;
        in_pkt   = 16'h5114;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("midrst");
        fwd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_resurrect", {30'd0, fwd_valid, loc_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(16'h0335, 1'b1, 1'b0, 16'h0235);
        drain("drain_t5");

`ifdef FWD_ERR_CNT_EN
        base = pulse_cnt;
        send(16'h0A35, 1'b0, 1'b0, 16'h0000);
        send(16'h0800, 1'b0, 1'b0, 16'h0000);
        send(16'h0F00, 1'b0, 1'b0, 16'h0000);
        send(16'h0901, 1'b0, 1'b0, 16'h0000);
        send(16'h0C00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("err_count_saturated", 32'(err_count), 32'd3);
        @(negedge clk);
        check("err_pulse_run", pulse_cnt - base, 32'd5);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(negedge clk);
        check("pulse_total", pulse_cnt, ill_sent);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fwd_stage.md
# fwd_stage

Parametrised, buffered forwarding stage for one output direction of the mesh router. Each packet carries a signed hop-count field. While hops remain in this stage's direction, the stage moves the packet one hop further and adjusts the field by one. When the field reaches zero, the packet is delivered to the local port. Packets pointing the wrong way are dropped and flagged. The stage sits between the router's input arbitration and the link or local-ejection interface for that direction, and decouples them with a small FIFO and valid/ready handshakes.

## Interface
- `PKT_W`, 16: packet width in bits.
- `HOP_LSB`, 8: bit position of the hop field LSB within the packet.
- `HOP_W`, 4: hop field width; the field is two's-complement signed.
- `DIR_NEG`, 0: 0 forwards when hop > 0 and decrements (south/east style); 1 forwards when hop < 0 and increments (north/west style).
- `DEPTH`, 4: FIFO depth; must be a power of 2 and at least 2.
- `ERR_CNT_W`, 8: error counter width.
- `clk` in 1: clock; every register is updated on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_pkt` in PKT_W: incoming packet.
- `in_valid` in 1: the incoming packet is valid.
- `in_ready` out 1: the stage can accept a packet.
- `fwd_pkt` out PKT_W: forwarded packet, with the hop field already adjusted.
- `fwd_valid` out 1 / `fwd_ready` in 1: forward-port handshake.
- `loc_pkt` out PKT_W: packet for local delivery, passed unmodified.
- `loc_valid` out 1 / `loc_ready` in 1: local-port handshake.
- `err_pulse` out 1: one-cycle strobe, raised once per dropped illegal packet.
- `err_count` out ERR_CNT_W: count of dropped packets, saturating; exists only when `FWD_ERR_CNT_EN` is defined.

## Operation
- **Accept:** a packet is accepted when `in_valid && in_ready`. `in_ready = !full`. A full FIFO does not pass a packet through in the same cycle as a pop.
- **Classification at accept** (h = hop field of `in_pkt`):
  - Legal-forward: h > 0 when DIR_NEG=0, or h < 0 when DIR_NEG=1.
  - Legal-local: h == 0.
  - Illegal: any other value.
- **Legal packets** are pushed into the FIFO unmodified.
- **Illegal packets** are consumed (the handshake still completes) but are not pushed. `err_pulse` goes high the following cycle.
- **FIFO head routing:** the FIFO head is classified combinationally.
  - Forward head: `fwd_valid` = 1. `fwd_pkt` is the head with its hop field replaced by h−1 (DIR_NEG=0) or h+1 (DIR_NEG=1). The arithmetic is done at HOP_W+1 bits and truncated to HOP_W bits. No other bits change.
  - Local head: `loc_valid` = 1 and `loc_pkt` = head.
  - Exactly one of `fwd_valid` and `loc_valid` is high when the FIFO is non-empty. Neither is high when it is empty.
- **Pop:** the head is popped when the asserted valid meets its ready. The ready of the other port is ignored. Delivery is strictly in order, so a stalled head blocks the packets behind it.
- **Output stability:** whichever of `fwd_pkt` or `loc_pkt` is not being driven reads all zeros. While a valid is high and its ready is low, the packet and valid hold stable.
- **Storage:**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is log2(DEPTH)+1 bits.
  - A push and a pop in the same cycle leave occupancy unchanged. This is legal whenever the FIFO is not full, including when it holds exactly 1 entry.

## Timing
- **Latency:** a packet accepted at edge N into an empty FIFO is presented at its output during cycle N+1, i.e. valid before edge N+1.
- **Throughput:** one packet per cycle when downstream is always ready.
- **`err_pulse`:** registered; high for exactly the cycle after the edge that accepted the illegal packet. Back-to-back illegal packets give consecutive pulses.
- **Reset:**
  - While `rst` is high on an edge, the FIFO empties, the pointers and occupancy clear, `err_pulse` = 0 and `err_count` = 0.
  - In the cycle after reset, `in_ready` = 1, `fwd_valid` = `loc_valid` = 0, and both packet outputs are 0.
  - Packets held in the FIFO when reset is asserted mid-operation are discarded. An `in_valid` that coincides with the reset edge is not accepted.

## Configuration
- `FWD_ERR_CNT_EN` defined:
  - `err_count` port and counter exist.
  - The counter increments once per illegal drop and saturates at 2^ERR_CNT_W − 1.
  - Reset clears it to 0.
- `FWD_ERR_CNT_EN` undefined:
  - The port and counter are absent.
  - `err_pulse` behaviour is unchanged.

## Test plan
1. DIR_NEG=0, `in_pkt`=16'h0A35 (h=+10? no, h=4'hA=−6), then 16'h0335 (h=+3) with both readies=1 → first is dropped with an `err_pulse`; second appears on `fwd_pkt`=16'h0235 one cycle later, and `loc_valid` stays 0.
2. DIR_NEG=0, `in_pkt`=16'h00C1 (h=0) → `loc_pkt`=16'h00C1 with `loc_valid`=1 next cycle; `fwd_valid`=0.
3. DIR_NEG=1, `in_pkt`=16'h0F12 (h=−1) → `fwd_pkt`=16'h0012.
4. DEPTH=4, `fwd_ready`=0, five forward packets offered back to back → four accepted and `in_ready`=0 from then on. Raise `fwd_ready` → the four drain in order, one per cycle, and the fifth is then accepted.
5. FIFO holding 2 packets, with a simultaneous push and pop every cycle for 10 cycles → occupancy stays 2, ordering is preserved and pointers wrap without loss. Then assert `rst` mid-stream → all valids are 0 the next cycle and `in_ready`=1.
6. `FWD_ERR_CNT_EN` defined, ERR_CNT_W=2, five illegal packets → five `err_pulse` cycles and `err_count` stops at 3.
